// File: rtl/sram_arbiter.sv
// Two-requester arbiter/sequencer for the single-port 16384x32 SRAM macro.
// Latches one request per grant, drives registered macro pins, returns Q with a one-cycle ready.
module sram_arbiter #(
    parameter int ADDR_W      = 14,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [31:0]       a_wdata,
    input  logic [3:0]        a_wstrb,
    output logic [31:0]       a_rdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       b_wdata,
    input  logic [3:0]        b_wstrb,
    output logic [31:0]       b_rdata,
    output logic [ADDR_W-1:0] sram_a,
    output logic [31:0]       sram_d,
    output logic [31:0]       sram_wen,
    output logic              sram_cen,
    input  logic [31:0]       sram_q,
    input  logic              sram_rdy
);

    // state | meaning
    // IDLE  | macro deselected, waiting for a request
    // ISSUE | CEn low, macro samples the request on this edge
    // RESP  | Q/RDY valid; complete (maybe chaining the other port) or retry
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            state, state_nxt;
    logic              gnt_b, gnt_b_nxt;
    logic              last_b, last_b_nxt;
    logic [3:0]        req_wstrb, req_wstrb_nxt;
    logic [ADDR_W-1:0] sram_a_nxt;
    logic [31:0]       sram_d_nxt, sram_wen_nxt;
    logic              sram_cen_nxt;
    logic              a_ready_nxt, b_ready_nxt;
    logic [31:0]       a_rdata_nxt, b_rdata_nxt;
    logic              issue, issue_b;

    function automatic logic [31:0] strb_to_wen(input logic [3:0] strb);
        logic [31:0] wen;
        wen = '1;
        for (int k = 0; k < 4; k++) begin
            wen[8*k +: 8] = {8{~strb[k]}};
        end
        return wen;
    endfunction

    always_comb begin
        state_nxt     = state;
        gnt_b_nxt     = gnt_b;
        last_b_nxt    = last_b;
        req_wstrb_nxt = req_wstrb;
        sram_a_nxt    = sram_a;
        sram_d_nxt    = sram_d;
        sram_wen_nxt  = '1;
        sram_cen_nxt  = 1'b1;
        a_ready_nxt   = 1'b0;
        b_ready_nxt   = 1'b0;
        a_rdata_nxt   = a_rdata;
        b_rdata_nxt   = b_rdata;
        issue         = 1'b0;
        issue_b       = 1'b0;

        case (state)
            IDLE: begin
                if (a_valid || b_valid) begin
                    issue   = 1'b1;
                    issue_b = b_valid && (!a_valid || (ROUND_ROBIN && !last_b));
                end
            end
            ISSUE: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (sram_rdy) begin
                    if (gnt_b) begin
                        b_ready_nxt = 1'b1;
                        b_rdata_nxt = sram_q;
                    end else begin
                        a_ready_nxt = 1'b1;
                        a_rdata_nxt = sram_q;
                    end
                    // only the other port may chain; the completing one goes back through IDLE
                    if (gnt_b ? a_valid : b_valid) begin
                        issue   = 1'b1;
                        issue_b = !gnt_b;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    sram_cen_nxt = 1'b0;
                    sram_wen_nxt = strb_to_wen(req_wstrb);
                    state_nxt    = ISSUE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (issue) begin
            state_nxt     = ISSUE;
            gnt_b_nxt     = issue_b;
            last_b_nxt    = issue_b;
            sram_cen_nxt  = 1'b0;
            sram_a_nxt    = issue_b ? b_addr  : a_addr;
            sram_d_nxt    = issue_b ? b_wdata : a_wdata;
            req_wstrb_nxt = issue_b ? b_wstrb : a_wstrb;
            sram_wen_nxt  = strb_to_wen(issue_b ? b_wstrb : a_wstrb);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            gnt_b     <= 1'b0;
            last_b    <= 1'b1;
            req_wstrb <= '0;
            sram_a    <= '0;
            sram_d    <= '0;
            sram_wen  <= '1;
            sram_cen  <= 1'b1;
            a_ready   <= 1'b0;
            b_ready   <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            state     <= state_nxt;
            gnt_b     <= gnt_b_nxt;
            last_b    <= last_b_nxt;
            req_wstrb <= req_wstrb_nxt;
            sram_a    <= sram_a_nxt;
            sram_d    <= sram_d_nxt;
            sram_wen  <= sram_wen_nxt;
            sram_cen  <= sram_cen_nxt;
            a_ready   <= a_ready_nxt;
            b_ready   <= b_ready_nxt;
            a_rdata   <= a_rdata_nxt;
            b_rdata   <= b_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: round-robin instance on a behavioural SRAM model,
// plus a fixed-priority instance on an address-echo model.
module tb_sram_arbiter;
    localparam int AW = 14;

    logic          CLK, RST;
    logic          a_valid, b_valid, a_ready, b_ready;
    logic [AW-1:0] a_addr, b_addr;
    logic [31:0]   a_wdata, b_wdata, a_rdata, b_rdata;
    logic [3:0]    a_wstrb, b_wstrb;
    logic [AW-1:0] sram_a;
    logic [31:0]   sram_d, sram_wen, sram_q;
    logic          sram_cen, sram_rdy;

    logic          fp_a_valid, fp_b_valid, fp_a_ready, fp_b_ready;
    logic [31:0]   fp_a_rdata, fp_b_rdata;
    logic [AW-1:0] fp_sram_a;
    logic [31:0]   fp_sram_d, fp_sram_wen, fp_q;
    logic          fp_sram_cen, fp_rdy;

    logic [31:0]   mem [0:16383];
    logic [31:0]   mdl_q;
    logic          mdl_rdy, kill;
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;

    int            n_chk = 0;
    int            n_fail = 0;
    logic [31:0]   rd, wcap;
    int            lat;

    sram_arbiter #(.ADDR_W(AW), .ROUND_ROBIN(1'b1)) dut (
        .CLK(CLK), .RST(RST),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_wstrb(a_wstrb), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_wstrb(b_wstrb), .b_rdata(b_rdata),
        .sram_a(sram_a), .sram_d(sram_d), .sram_wen(sram_wen), .sram_cen(sram_cen),
        .sram_q(sram_q), .sram_rdy(sram_rdy)
    );

    sram_arbiter #(.ADDR_W(AW), .ROUND_ROBIN(1'b0)) dut_fp (
        .CLK(CLK), .RST(RST),
        .a_valid(fp_a_valid), .a_ready(fp_a_ready), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_wstrb(a_wstrb), .a_rdata(fp_a_rdata),
        .b_valid(fp_b_valid), .b_ready(fp_b_ready), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_wstrb(b_wstrb), .b_rdata(fp_b_rdata),
        .sram_a(fp_sram_a), .sram_d(fp_sram_d), .sram_wen(fp_sram_wen), .sram_cen(fp_sram_cen),
        .sram_q(fp_q), .sram_rdy(fp_rdy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // read-before-write macro model; RDY/Q forced low while deselected
    always @(posedge CLK) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (!sram_cen) begin
            mdl_q        <= mem[sram_a];
            mdl_rdy      <= 1'b1;
            mem[sram_a]  <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
        end else begin
            mdl_q   <= '0;
            mdl_rdy <= 1'b0;
        end
    end
    assign sram_q   = mdl_q;
    assign sram_rdy = mdl_rdy & ~kill;

    always @(posedge CLK) begin
        fp_rdy <= !fp_sram_cen;
        fp_q   <= fp_sram_cen ? 32'h0 : {18'h0, fp_sram_a};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] addr, input logic [31:0] data);
        pl_en   = 1'b1;
        pl_addr = addr;
        pl_data = data;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic access(input logic pb, input logic [AW-1:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, output logic [31:0] rdo, output int lato,
                          output logic [31:0] wen_cap);
        logic done, seen;
        done = 1'b0;
        seen = 1'b0;
        wen_cap = '1;
        lato = 0;
        if (pb) begin
            b_addr = addr; b_wdata = wd; b_wstrb = ws; b_valid = 1'b1;
        end else begin
            a_addr = addr; a_wdata = wd; a_wstrb = ws; a_valid = 1'b1;
        end
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            lato++;
            if (!sram_cen && !seen) begin
                wen_cap = sram_wen;
                seen = 1'b1;
            end
            done = pb ? b_ready : a_ready;
        end
        chk("acc_ready", done, 1'b1);
        chk("acc_other_ready", pb ? a_ready : b_ready, 1'b0);
        rdo = pb ? b_rdata : a_rdata;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_a, cnt_b, n_ev;
        RST = 1'b1; kill = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        a_valid = 0; b_valid = 0; fp_a_valid = 0; fp_b_valid = 0;
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0; a_wstrb = '0; b_wstrb = '0;

        preload(14'h0123, 32'hCAFEF00D);
        preload(14'h0010, 32'hAABBCCDD);
        preload(14'h0001, 32'h11111111);
        preload(14'h0002, 32'h22222222);

        // reset values
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdata", b_rdata, 0);
        chk("rst_cen", sram_cen, 1);
        chk("rst_wen", sram_wen, 32'hFFFFFFFF);
        chk("rst_sram_a", sram_a, 0);
        chk("rst_sram_d", sram_d, 0);
        chk("rst_fp_sram_d", fp_sram_d, 0);
        RST = 1'b0;

        // idle power
        repeat (100) begin
            tick();
            chk("idle_main", {sram_cen, sram_wen}, {1'b1, 32'hFFFFFFFF});
            chk("idle_fp", {fp_sram_cen, fp_sram_wen}, {1'b1, 32'hFFFFFFFF});
        end

        // round-robin conflict, 4 reads per port, A wins first
        a_addr = 14'h1; b_addr = 14'h2; a_wstrb = 0; b_wstrb = 0;
        a_valid = 1; b_valid = 1;
        cnt_a = 0; cnt_b = 0; n_ev = 0;
        for (int s = 1; s <= 20; s++) begin
            tick();
            if (a_ready || b_ready) begin
                chk("rr_onehot", a_ready & b_ready, 0);
                chk("rr_port", b_ready, n_ev % 2);
                chk("rr_step", s, 3 + 2 * n_ev);
                chk("rr_data", b_ready ? b_rdata : a_rdata, b_ready ? 32'h22222222 : 32'h11111111);
                n_ev++;
                if (a_ready) begin cnt_a++; if (cnt_a == 4) a_valid = 0; end
                if (b_ready) begin cnt_b++; if (cnt_b == 4) b_valid = 0; end
            end
        end
        chk("rr_count", n_ev, 8);

        // single read, exact latency, on both instances
        a_addr = 14'h0123; a_wstrb = 0; a_valid = 1; fp_a_valid = 1;
        tick();
        chk("rd_cen_low", sram_cen, 0);
        chk("rd_sram_a", sram_a, 14'h0123);
        chk("rd_wen", sram_wen, 32'hFFFFFFFF);
        tick();
        chk("rd_cen_high", sram_cen, 1);
        chk("rd_early_ready", a_ready, 0);
        tick();
        chk("rd_ready", a_ready, 1);
        chk("rd_data", a_rdata, 32'hCAFEF00D);
        chk("rd_b_ready", b_ready, 0);
        chk("fp_rd_ready", fp_a_ready, 1);
        chk("fp_rd_data", fp_a_rdata, 32'h123);
        a_valid = 0; fp_a_valid = 0;
        tick();
        chk("rd_pulse", a_ready, 0);

        // A was granted last: round-robin now favours B, fixed priority still A
        a_addr = 14'h1; b_addr = 14'h2;
        a_valid = 1; b_valid = 1; fp_a_valid = 1; fp_b_valid = 1;
        for (int s = 1; s <= 8; s++) begin
            tick();
            if (a_ready) begin chk("rr2_a_step", s, 5); chk("rr2_a_data", a_rdata, 32'h11111111); a_valid = 0; end
            if (b_ready) begin chk("rr2_b_step", s, 3); chk("rr2_b_data", b_rdata, 32'h22222222); b_valid = 0; end
            if (fp_a_ready) begin chk("fp_a_step", s, 3); chk("fp_a_data", fp_a_rdata, 32'h1); fp_a_valid = 0; end
            if (fp_b_ready) begin chk("fp_b_step", s, 5); chk("fp_b_data", fp_b_rdata, 32'h2); fp_b_valid = 0; end
        end
        chk("rr2_done", {a_valid, b_valid, fp_a_valid, fp_b_valid}, 0);

        // partial byte write then read back on both ports
        access(1'b0, 14'h0010, 32'h11223344, 4'b0101, rd, lat, wcap);
        chk("wr_lat", lat, 3);
        chk("wr_wen", wcap, 32'hFF00FF00);
        access(1'b0, 14'h0010, 32'h0, 4'b0000, rd, lat, wcap);
        chk("wr_rb_a", rd, 32'hAA22CC44);
        chk("wr_rb_lat", lat, 3);
        access(1'b1, 14'h0010, 32'h0, 4'b0000, rd, lat, wcap);
        chk("wr_rb_b", rd, 32'hAA22CC44);

        // retry: RDY low for one RESP cycle
        b_addr = 14'h0123; b_wstrb = 0; b_valid = 1;
        tick();
        chk("rt_cen1", sram_cen, 0);
        tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        chk("rt_no_ready", b_ready, 0);
        chk("rt_cen2", sram_cen, 0);
        chk("rt_addr", sram_a, 14'h0123);
        tick();
        chk("rt_cen3", sram_cen, 1);
        tick();
        chk("rt_ready", b_ready, 1);
        chk("rt_data", b_rdata, 32'hCAFEF00D);
        chk("rt_a_rdata_hold", a_rdata, 32'hAA22CC44);
        b_valid = 0;
        tick();

        // reset during ISSUE drops the access; valid held across reset
        a_addr = 14'h0123; a_wstrb = 0; a_valid = 1;
        tick();
        chk("mr_cen_issue", sram_cen, 0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mr_cen", sram_cen, 1);
        chk("mr_wen", sram_wen, 32'hFFFFFFFF);
        chk("mr_ready", a_ready, 0);
        chk("mr_rdata", a_rdata, 0);
        tick();
        chk("mr_reissue_cen", sram_cen, 0);
        chk("mr_reissue_ready", a_ready, 0);
        tick();
        chk("mr_issue_ready", a_ready, 0);
        tick();
        chk("mr_done_ready", a_ready, 1);
        chk("mr_done_data", a_rdata, 32'hCAFEF00D);
        a_valid = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
